fetch_pcgen: RTL and testbench
==============================

Name: fetch_pcgen

Overview:
- Fetch-stage PC generator and instruction buffer. It sits directly upstream of decode and consumes decode's branch/jump target (pcsrc) and taken flag.
- Holds the architectural fetch PC and issues one instruction-bus request at a time.
- Buffers the returned instruction toward decode with a valid/ready handshake.
- Squashes any in-flight or buffered instruction when decode redirects.

Parameters:
PCINIT, 64'h0000_0000_8000_0000, fetch PC loaded at reset
INSTR_BYTES, 4, sequential PC increment (RV64I, no compressed)

Ports:
clk  in  1  clock, rising edge
resetn  in  1  reset, asynchronous, active-low
redirect_valid  in  1  decode: taken branch/JAL/JALR this cycle
redirect_pc  in  64  decode: target (pcsrc)
ireq_valid  out  1  instruction bus request
ireq_addr  out  64  request address
iresp_data_ok  in  1  bus response valid (1 cycle pulse)
iresp_data  in  32  fetched instruction
f_valid  out  1  instruction valid to decode
f_pc  out  64  PC of f_instr
f_instr  out  32  instruction to decode
d_ready  in  1  decode accepts f_* this cycle

Behaviour:
- Reset (resetn=0, async):
  - state=BOOT, pc=PCINIT, tgt=0.
  - ireq_valid=0, ireq_addr=PCINIT, f_valid=0, f_pc=0, f_instr=0.
- States: BOOT, FETCH, HOLD, DISCARD.
- BOOT: outputs idle; next cycle goes to FETCH unconditionally. A redirect in BOOT loads pc=redirect_pc.
- FETCH:
  - ireq_valid=1, ireq_addr=pc.
  - Address and valid stay stable until iresp_data_ok; a request is never withdrawn.
  - Only one request is outstanding.
- FETCH, iresp_data_ok=1, no redirect:
  - Latch f_pc=pc, f_instr=iresp_data; go to HOLD.
  - f_valid=1 from the next cycle (data_ok at cycle N, f_valid at N+1).
- FETCH, redirect_valid=1, no data_ok: tgt=redirect_pc; go to DISCARD.
- FETCH, redirect_valid and iresp_data_ok in the same cycle:
  - Response dropped.
  - pc=redirect_pc; stay FETCH with the new address from the next cycle.
- DISCARD:
  - ireq_valid=0, f_valid=0.
  - On iresp_data_ok the response is dropped, pc=tgt, go to FETCH.
  - A further redirect overwrites tgt (last wins). Redirect coinciding with data_ok uses the new redirect_pc.
- HOLD:
  - f_valid=1; f_pc and f_instr stable while d_ready=0.
  - ireq_valid=0.
- HOLD, d_ready=1, no redirect: pc=f_pc+INSTR_BYTES; go to FETCH; f_valid=0 next cycle.
- HOLD, redirect_valid=1 (regardless of d_ready):
  - Buffer squashed: f_valid=0 next cycle.
  - pc=redirect_pc; go to FETCH.
  - Decode must not consume f_* in a cycle in which it asserts redirect for an older instruction.
- Arithmetic:
  - pc+4 is 64-bit and wraps modulo 2^64 (0xFFFF_FFFF_FFFF_FFFC -> 0).
  - redirect_pc is used unmodified: no alignment check, low bits passed through.
- Throughput: one instruction every 2 cycles minimum with single-cycle bus latency. No prefetch.
- Reset asserted mid-request: state returns to BOOT immediately. Any later iresp_data_ok for the old request is ignored because BOOT does not sample the response.

Test Plan:
- Reset release, bus returns data_ok 1 cycle after each request, d_ready=1:
  - ireq_addr sequence 0x80000000, 0x80000004, 0x80000008.
  - f_valid pulses with f_pc matching each address and f_instr matching the data returned.
- d_ready=0 for 5 cycles in HOLD: f_valid, f_pc and f_instr held constant; ireq_valid=0 throughout; on d_ready=1 next ireq_addr=f_pc+4.
- Redirect to 0x80001000 while a request is outstanding (bus latency 3):
  - ireq_valid drops.
  - Old response never appears on f_*.
  - Next request addr=0x80001000.
- Redirect and iresp_data_ok in the same cycle (target 0x80002000): response dropped; next ireq_addr=0x80002000; f_valid stays 0.
- Two redirects in DISCARD (0x100 then 0x200): next fetch at 0x200.
- pc=0xFFFF_FFFF_FFFF_FFFC accepted by decode: next ireq_addr=0.
- resetn pulsed low mid-request: outputs go to reset values asynchronously; first request after release is at PCINIT.

Source files
------------

// File: rtl/fetch_pcgen.sv
// Fetch-stage PC generator and single-entry instruction buffer toward decode.
// Latency: response accepted at cycle N is presented to decode at N+1; one instruction per 2 cycles at best.
// Backpressure: the buffer holds f_* stable while d_ready=0; no new request is issued until decode takes it.
//
// Ports:
//   clk, resetn                    - clock (rising edge), asynchronous active-low reset
//   redirect_valid, redirect_pc    - taken branch/jump target from decode
//   ireq_valid, ireq_addr          - instruction bus request (one outstanding, never withdrawn)
//   iresp_data_ok, iresp_data      - instruction bus response (single-cycle pulse)
//   f_valid, f_pc, f_instr         - buffered instruction toward decode
//   d_ready                        - decode accepts f_* this cycle
module fetch_pcgen #(
  parameter logic [63:0] PCINIT      = 64'h0000_0000_8000_0000,
  parameter int          INSTR_BYTES = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  output logic        f_valid,
  output logic [63:0] f_pc,
  output logic [31:0] f_instr,
  input  logic        d_ready
);

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    FETCH   = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } state_t;

  state_t      r_state;
  logic [63:0] r_pc;
  logic [63:0] r_tgt;
  logic [63:0] r_f_pc;
  logic [31:0] r_f_instr;

  state_t      w_state_nxt;
  logic [63:0] w_pc_nxt;
  logic [63:0] w_tgt_nxt;
  logic [63:0] w_f_pc_nxt;
  logic [31:0] w_f_instr_nxt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= BOOT;
      r_pc      <= PCINIT;
      r_tgt     <= 64'd0;
      r_f_pc    <= 64'd0;
      r_f_instr <= 32'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_tgt     <= w_tgt_nxt;
      r_f_pc    <= w_f_pc_nxt;
      r_f_instr <= w_f_instr_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_tgt_nxt     = r_tgt;
    w_f_pc_nxt    = r_f_pc;
    w_f_instr_nxt = r_f_instr;
    case (r_state)
      BOOT: begin
        // The bus response is deliberately not sampled here, so a reply to a
        // request that was cut off by reset can never reach decode.
        if (redirect_valid) w_pc_nxt = redirect_pc;
        w_state_nxt = FETCH;
      end
      FETCH: begin
        if (iresp_data_ok && redirect_valid) begin
          // Response belongs to the wrong path; re-issue at the target.
          w_pc_nxt = redirect_pc;
        end else if (iresp_data_ok) begin
          w_f_pc_nxt    = r_pc;
          w_f_instr_nxt = iresp_data;
          w_state_nxt   = HOLD;
        end else if (redirect_valid) begin
          // Request cannot be withdrawn: park the target until the bus answers.
          w_tgt_nxt   = redirect_pc;
          w_state_nxt = DISCARD;
        end
      end
      DISCARD: begin
        if (iresp_data_ok) begin
          w_pc_nxt    = redirect_valid ? redirect_pc : r_tgt;
          w_state_nxt = FETCH;
        end else if (redirect_valid) begin
          w_tgt_nxt = redirect_pc;
        end
      end
      HOLD: begin
        // Redirect wins over d_ready: decode never consumes in a redirect cycle.
        if (redirect_valid) begin
          w_pc_nxt    = redirect_pc;
          w_state_nxt = FETCH;
        end else if (d_ready) begin
          w_pc_nxt    = r_f_pc + 64'(INSTR_BYTES);
          w_state_nxt = FETCH;
        end
      end
      default: w_state_nxt = BOOT;
    endcase
  end

  assign ireq_valid = (r_state == FETCH);
  assign ireq_addr  = r_pc;
  assign f_valid    = (r_state == HOLD);
  assign f_pc       = r_f_pc;
  assign f_instr    = r_f_instr;

endmodule

// File: tb/tb_fetch_pcgen.sv
// Directed self-checking bench for fetch_pcgen.
// Inputs are driven and outputs sampled on the falling clock edge.
// Each scenario task leaves the DUT in FETCH for the next one.
module tb_fetch_pcgen;

  localparam logic [63:0] PCINIT = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = 64'd0;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok = 1'b0;
  logic [31:0] iresp_data = 32'd0;
  logic        f_valid;
  logic [63:0] f_pc;
  logic [31:0] f_instr;
  logic        d_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  fetch_pcgen #(.PCINIT(PCINIT), .INSTR_BYTES(4)) dut (
    .clk(clk), .resetn(resetn),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
    .f_valid(f_valid), .f_pc(f_pc), .f_instr(f_instr),
    .d_ready(d_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    step(); step();
    checks++; if (ireq_valid !== 1'b0) begin errors++; $display("FAIL reset_ireq_valid: got %b want 0", ireq_valid); end
    checks++; if (ireq_addr !== PCINIT) begin errors++; $display("FAIL reset_ireq_addr: got %h want %h", ireq_addr, PCINIT); end
    checks++; if (f_valid !== 1'b0) begin errors++; $display("FAIL reset_f_valid: got %b want 0", f_valid); end
    checks++; if (f_pc !== 64'd0) begin errors++; $display("FAIL reset_f_pc: got %h want 0", f_pc); end
    checks++; if (f_instr !== 32'd0) begin errors++; $display("FAIL reset_f_instr: got %h want 0", f_instr); end
    resetn = 1'b1;
    step(); // BOOT -> FETCH
  endtask

  task automatic test_sequential();
    logic [63:0] a;
    logic [31:0] d;
    d_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = PCINIT + 64'(4 * i);
      d = 32'h0000_0013 + 32'(i << 8);
      checks++; if (ireq_valid !== 1'b1 || ireq_addr !== a) begin errors++; $display("FAIL seq_req%0d: got v=%b a=%h want v=1 a=%h", i, ireq_valid, ireq_addr, a); end
      checks++; if (f_valid !== 1'b0) begin errors++; $display("FAIL seq_fvalid_low%0d: got %b want 0", i, f_valid); end
      iresp_data_ok = 1'b1; iresp_data = d;
      step();
      iresp_data_ok = 1'b0;
      checks++; if (f_valid !== 1'b1 || f_pc !== a || f_instr !== d) begin errors++; $display("FAIL seq_out%0d: got v=%b pc=%h i=%h want v=1 pc=%h i=%h", i, f_valid, f_pc, f_instr, a, d); end
      checks++; if (ireq_valid !== 1'b0) begin errors++; $display("FAIL seq_noreq%0d: got %b want 0", i, ireq_valid); end
      step();
    end
  endtask

  task automatic test_stall();
    // FETCH at 0x8000000C
    d_ready = 1'b0;
    iresp_data_ok = 1'b1; iresp_data = 32'hCAFE_0001;
    step();
    iresp_data_ok = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (f_valid !== 1'b1 || f_pc !== 64'h8000_000C || f_instr !== 32'hCAFE_0001) begin errors++; $display("FAIL stall_hold%0d: got v=%b pc=%h i=%h want v=1 pc=8000000c i=cafe0001", i, f_valid, f_pc, f_instr); end
      checks++; if (ireq_valid !== 1'b0) begin errors++; $display("FAIL stall_noreq%0d: got %b want 0", i, ireq_valid); end
      step();
    end
    d_ready = 1'b1;
    step();
    checks++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0010) begin errors++; $display("FAIL stall_next: got v=%b a=%h want v=1 a=80000010", ireq_valid, ireq_addr); end
    checks++; if (f_valid !== 1'b0) begin errors++; $display("FAIL stall_fvalid_drop: got %b want 0", f_valid); end
  endtask

  task automatic test_redirect_outstanding();
    // Request at 0x80000010 with 3-cycle bus latency; redirect in cycle 2.
    step();
    redirect_valid = 1'b1; redirect_pc = 64'h8000_1000;
    step();
    redirect_valid = 1'b0;
    checks++; if (ireq_valid !== 1'b0 || f_valid !== 1'b0) begin errors++; $display("FAIL redir_discard: got req=%b fv=%b want 0 0", ireq_valid, f_valid); end
    iresp_data_ok = 1'b1; iresp_data = 32'hDEAD_BEEF;
    step();
    iresp_data_ok = 1'b0;
    checks++; if (f_valid !== 1'b0) begin errors++; $display("FAIL redir_stale_fvalid: got %b want 0", f_valid); end
    checks++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_1000) begin errors++; $display("FAIL redir_newreq: got v=%b a=%h want v=1 a=80001000", ireq_valid, ireq_addr); end
    iresp_data_ok = 1'b1; iresp_data = 32'h1111_2222;
    step();
    iresp_data_ok = 1'b0;
    checks++; if (f_valid !== 1'b1 || f_pc !== 64'h8000_1000 || f_instr !== 32'h1111_2222) begin errors++; $display("FAIL redir_out: got v=%b pc=%h i=%h want v=1 pc=80001000 i=11112222", f_valid, f_pc, f_instr); end
    step();
  endtask

  task automatic test_redirect_same_cycle();
    // FETCH at 0x80001004
    redirect_valid = 1'b1; redirect_pc = 64'h8000_2000;
    iresp_data_ok = 1'b1; iresp_data = 32'h0BAD_0BAD;
    step();
    redirect_valid = 1'b0; iresp_data_ok = 1'b0;
    checks++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_2000) begin errors++; $display("FAIL same_req: got v=%b a=%h want v=1 a=80002000", ireq_valid, ireq_addr); end
    checks++; if (f_valid !== 1'b0) begin errors++; $display("FAIL same_fvalid: got %b want 0", f_valid); end
    iresp_data_ok = 1'b1; iresp_data = 32'h3333_4444;
    step();
    iresp_data_ok = 1'b0;
    checks++; if (f_valid !== 1'b1 || f_pc !== 64'h8000_2000 || f_instr !== 32'h3333_4444) begin errors++; $display("FAIL same_out: got v=%b pc=%h i=%h want v=1 pc=80002000 i=33334444", f_valid, f_pc, f_instr); end
    step();
  endtask

  task automatic test_discard_two();
    // FETCH at 0x80002004
    redirect_valid = 1'b1; redirect_pc = 64'h100;
    step();
    redirect_pc = 64'h200;
    step();
    redirect_valid = 1'b0;
    checks++; if (ireq_valid !== 1'b0 || f_valid !== 1'b0) begin errors++; $display("FAIL disc2_idle: got req=%b fv=%b want 0 0", ireq_valid, f_valid); end
    iresp_data_ok = 1'b1; iresp_data = 32'h5555_5555;
    step();
    iresp_data_ok = 1'b0;
    checks++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h200) begin errors++; $display("FAIL disc2_req: got v=%b a=%h want v=1 a=200", ireq_valid, ireq_addr); end
    checks++; if (f_valid !== 1'b0) begin errors++; $display("FAIL disc2_fvalid: got %b want 0", f_valid); end
  endtask

  task automatic test_wrap();
    // FETCH at 0x200: same-cycle redirect jumps straight to the top of memory.
    redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    iresp_data_ok = 1'b1;
    step();
    redirect_valid = 1'b0;
    checks++; if (ireq_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_top: got %h want fffffffffffffffc", ireq_addr); end
    iresp_data = 32'h7777_0001;
    step();
    iresp_data_ok = 1'b0;
    checks++; if (f_valid !== 1'b1 || f_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_hold: got v=%b pc=%h want v=1 pc=fffffffffffffffc", f_valid, f_pc); end
    d_ready = 1'b1;
    step();
    checks++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'd0) begin errors++; $display("FAIL wrap_zero: got v=%b a=%h want v=1 a=0", ireq_valid, ireq_addr); end
  endtask

  task automatic test_hold_redirect();
    // FETCH at 0: fill buffer, then squash it with an unaligned target while stalled.
    d_ready = 1'b0;
    iresp_data_ok = 1'b1; iresp_data = 32'h8888_0000;
    step();
    iresp_data_ok = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 64'h302;
    step();
    redirect_valid = 1'b0;
    checks++; if (f_valid !== 1'b0) begin errors++; $display("FAIL holdredir_squash: got %b want 0", f_valid); end
    checks++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h302) begin errors++; $display("FAIL holdredir_req: got v=%b a=%h want v=1 a=302", ireq_valid, ireq_addr); end
  endtask

  task automatic test_reset_mid();
    // FETCH at 0x302: buffer it, let decode take it, so f_pc is non-zero mid-request.
    iresp_data_ok = 1'b1; iresp_data = 32'h9999_0000;
    step();
    iresp_data_ok = 1'b0;
    d_ready = 1'b1;
    step();
    checks++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h306 || f_pc !== 64'h302) begin errors++; $display("FAIL rstmid_pre: got v=%b a=%h fpc=%h want v=1 a=306 fpc=302", ireq_valid, ireq_addr, f_pc); end
    #1 resetn = 1'b0;
    #1;
    checks++; if (ireq_valid !== 1'b0 || ireq_addr !== PCINIT) begin errors++; $display("FAIL rstmid_req: got v=%b a=%h want v=0 a=%h", ireq_valid, ireq_addr, PCINIT); end
    checks++; if (f_valid !== 1'b0 || f_pc !== 64'd0 || f_instr !== 32'd0) begin errors++; $display("FAIL rstmid_out: got v=%b pc=%h i=%h want 0 0 0", f_valid, f_pc, f_instr); end
    @(negedge clk);
    // Stale response arrives in the BOOT cycle after release and must be ignored.
    resetn = 1'b1;
    iresp_data_ok = 1'b1; iresp_data = 32'hABAD_CAFE;
    step();
    iresp_data_ok = 1'b0;
    checks++; if (ireq_valid !== 1'b1 || ireq_addr !== PCINIT || f_valid !== 1'b0) begin errors++; $display("FAIL rstmid_first: got v=%b a=%h fv=%b want v=1 a=%h fv=0", ireq_valid, ireq_addr, f_valid, PCINIT); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_outstanding();
    test_redirect_same_cycle();
    test_discard_two();
    test_wrap();
    test_hold_redirect();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
